spmm_row_scheduler: RTL and testbench
=====================================

Name: spmm_row_scheduler

Overview:
- Sequences the 4-lane multicast multiplier for one SpMM output row: C[i,:] = sum over k of A[i,k] * B[k,:].
- Accepts a stream of A nonzeros (value, column, last-in-row), fetches row B[k] from the B row buffer, multicasts the scalar across lanes and accumulates products.
- Emits the finished C row over a valid/ready handshake.
- Sits between the CSR nonzero streamer (upstream), the B row buffer, and the C writeback unit (downstream).

Parameters:
- DATA_W, 32, element width per lane.
- LANES, 4, elements per B/C row; row width is LANES*DATA_W.
- COL_W, 8, column index width, used as the B buffer row address.
- CNT_W, 16, width of the row and nonzero statistic counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  synchronous active-low reset.
- nz_valid_i  in  1  nonzero available.
- nz_ready_o  out  1  scheduler accepts nonzero.
- nz_val_i  in  DATA_W  A value.
- nz_col_i  in  COL_W  A column index k.
- nz_last_i  in  1  final nonzero of the current row.
- b_req_o  out  1  one-cycle B row read request.
- b_addr_o  out  COL_W  B row address.
- b_rvalid_i  in  1  B read data valid.
- b_rdata_i  in  LANES*DATA_W  B row, lane 0 in the LSBs.
- c_valid_o  out  1  C row valid.
- c_ready_i  in  1  downstream accepts the C row.
- c_row_o  out  LANES*DATA_W  accumulated C row.
- busy_o  out  1  not in IDLE.
- row_cnt_o  out  CNT_W  C rows emitted.
- nnz_cnt_o  out  CNT_W  nonzeros multiplied.

Behaviour:
- Reset (rst_ni=0 at a clock edge, synchronous) forces:
  - state IDLE; accumulator, latched value/column/last, row_cnt_o and nnz_cnt_o all 0.
  - b_req_o=0, b_addr_o=0, c_valid_o=0, busy_o=0, nz_ready_o=0 during the reset cycle.
  - A reset mid-row discards the partial row, and no C row is emitted for it.
- States:
  - IDLE: nz_ready_o=1. On nz_valid_i&&nz_ready_o, latch value, column and last, then go to FETCH.
  - FETCH: b_req_o=1 and b_addr_o=latched column for exactly one cycle, then go to WAIT.
  - WAIT: hold until b_rvalid_i; capture b_rdata_i, then go to MAC. b_rvalid_i in any other state is ignored.
  - MAC: for each lane, acc[l] = acc[l] + low DATA_W bits of (B[l] * value). Products and sums are unsigned and wrap modulo 2^DATA_W. nnz_cnt_o is incremented. Next state is EMIT if last is set, otherwise IDLE.
  - EMIT: c_valid_o=1 and c_row_o=acc, held stable until c_ready_i. On the handshake, clear the accumulator, increment row_cnt_o and go to IDLE.
- nz_ready_o is 0 in every state except IDLE. Upstream stalls during fetch, MAC and a backpressured EMIT.
- Throughput per nonzero: 3 cycles + B read latency (accept, FETCH, WAIT≥1, MAC).
- Latency from the last nonzero's acceptance to c_valid_o: that nonzero's cost plus 1 cycle.
- c_row_o is driven from the accumulator register at all times and is only meaningful while c_valid_o=1.
- Counters wrap at 2^CNT_W.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: SPMM_SKIP_ZERO_EN.
- Defined:
  - An accepted nonzero with value 0 skips FETCH/WAIT/MAC, issues no b_req_o and does not increment nnz_cnt_o.
  - If its last bit is set, go directly to EMIT on the next cycle. An empty row (a single zero nonzero with last set) therefore emits all zeros.
- Not defined: zero values are processed like any other value.

Decomposition:
- Package spmm_pkg holds:
  - the state enum (IDLE, FETCH, WAIT, MAC, EMIT);
  - default constants DATA_W/LANES/COL_W;
  - typedef row_t = logic [LANES*DATA_W-1:0].
- Sub-module lane_mult_array: a LANES-wide scalar-broadcast multiplier (combinational, truncated products), instantiated once and fed by the latched value and the captured B row.

Test Plan:
- Row with nonzeros (val=2,col=3) and (val=3,col=5,last=1); B[3]={1,2,3,4} and B[5]={10,20,30,40} (lanes 0..3) → C row lanes 0..3 = {32,64,96,128}, row_cnt_o=1, nnz_cnt_o=2.
- Read latency 1 vs 5 with b_rvalid_i asserted late → identical C row; b_req_o pulses exactly once per nonzero; nz_ready_o stays 0 until MAC completes.
- Hold c_ready_i=0 for 10 cycles in EMIT → c_valid_o and c_row_o stable, nz_valid_i held high not accepted; c_ready_i=1 → accumulator cleared, the next row starts from 0.
- Overflow: val=0xFFFF_FFFF, B row all 2 → each lane 0xFFFF_FFFE (truncated); accumulating a second identical nonzero → 0xFFFF_FFFC.
- rst_ni pulled low during WAIT of a multi-nonzero row → all outputs 0 next cycle; a following fresh row's C row contains no residue of the aborted row.
- SPMM_SKIP_ZERO_EN defined: nonzero (val=0,col=7,last=1) → no b_req_o, c_valid_o two cycles after acceptance, C row=0. Macro undefined: b_req_o with addr 7 is issued and the C row is still 0.

Source files
------------

// File: rtl/spmm_pkg.sv
// Shared types and default widths for the SpMM row scheduler slice.
package spmm_pkg;

    localparam int DATA_W = 32;
    localparam int LANES  = 4;
    localparam int COL_W  = 8;
    localparam int CNT_W  = 16;

    typedef logic [LANES*DATA_W-1:0] row_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        MAC,
        EMIT
    } state_t;

endpackage

// File: rtl/spmm_row_scheduler_if.sv
// Bundles the nonzero stream, B buffer read port, C writeback handshake and statistics.
interface spmm_row_scheduler_if #(
    parameter int DATA_W = spmm_pkg::DATA_W,
    parameter int LANES  = spmm_pkg::LANES,
    parameter int COL_W  = spmm_pkg::COL_W,
    parameter int CNT_W  = spmm_pkg::CNT_W
);
    logic                    nz_valid_i;
    logic                    nz_ready_o;
    logic [DATA_W-1:0]       nz_val_i;
    logic [COL_W-1:0]        nz_col_i;
    logic                    nz_last_i;
    logic                    b_req_o;
    logic [COL_W-1:0]        b_addr_o;
    logic                    b_rvalid_i;
    logic [LANES*DATA_W-1:0] b_rdata_i;
    logic                    c_valid_o;
    logic                    c_ready_i;
    logic [LANES*DATA_W-1:0] c_row_o;
    logic                    busy_o;
    logic [CNT_W-1:0]        row_cnt_o;
    logic [CNT_W-1:0]        nnz_cnt_o;

    // slave: the scheduler itself; master: its surroundings
    modport slave (
        input  nz_valid_i, nz_val_i, nz_col_i, nz_last_i, b_rvalid_i, b_rdata_i, c_ready_i,
        output nz_ready_o, b_req_o, b_addr_o, c_valid_o, c_row_o, busy_o, row_cnt_o, nnz_cnt_o
    );

    modport master (
        output nz_valid_i, nz_val_i, nz_col_i, nz_last_i, b_rvalid_i, b_rdata_i, c_ready_i,
        input  nz_ready_o, b_req_o, b_addr_o, c_valid_o, c_row_o, busy_o, row_cnt_o, nnz_cnt_o
    );

endinterface

// File: rtl/lane_mult_array.sv
// Broadcasts one scalar across LANES elements; each product is truncated to DATA_W bits.
module lane_mult_array #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4
) (
    input  logic [DATA_W-1:0]       scalar_i,
    input  logic [LANES*DATA_W-1:0] row_i,
    output logic [LANES*DATA_W-1:0] prod_o
);

    always_comb begin
        prod_o = '0;
        for (int l = 0; l < LANES; l++) begin
            prod_o[l*DATA_W +: DATA_W] = row_i[l*DATA_W +: DATA_W] * scalar_i;
        end
    end

endmodule

// File: rtl/spmm_row_scheduler.sv
// Accumulates one SpMM output row from a stream of A nonzeros and emits it downstream.
// Optional build macro SPMM_SKIP_ZERO_EN: zero-valued nonzeros skip the B fetch and MAC.
//
// state | meaning
// IDLE  | ready for the next nonzero
// FETCH | one-cycle B row read request
// WAIT  | waiting for B read data
// MAC   | accumulate lane products into the row
// EMIT  | C row offered downstream until accepted
module spmm_row_scheduler #(
    parameter int DATA_W = spmm_pkg::DATA_W,
    parameter int LANES  = spmm_pkg::LANES,
    parameter int COL_W  = spmm_pkg::COL_W,
    parameter int CNT_W  = spmm_pkg::CNT_W
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    spmm_row_scheduler_if.slave bus
);
    import spmm_pkg::*;

    localparam int ROW_W = LANES*DATA_W;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  val_q, val_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               last_q, last_d;
    logic [ROW_W-1:0]   brow_q, brow_d;
    logic [ROW_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0]   nnz_cnt_q, nnz_cnt_d;
    logic [ROW_W-1:0]   prod;
    logic               nz_ready, b_req, c_valid;

    lane_mult_array #(.DATA_W(DATA_W), .LANES(LANES)) u_mult (
        .scalar_i (val_q),
        .row_i    (brow_q),
        .prod_o   (prod)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            val_q     <= '0;
            col_q     <= '0;
            last_q    <= 1'b0;
            brow_q    <= '0;
            acc_q     <= '0;
            row_cnt_q <= '0;
            nnz_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            col_q     <= col_d;
            last_q    <= last_d;
            brow_q    <= brow_d;
            acc_q     <= acc_d;
            row_cnt_q <= row_cnt_d;
            nnz_cnt_q <= nnz_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        col_d     = col_q;
        last_d    = last_q;
        brow_d    = brow_q;
        acc_d     = acc_q;
        row_cnt_d = row_cnt_q;
        nnz_cnt_d = nnz_cnt_q;
        nz_ready  = 1'b0;
        b_req     = 1'b0;
        c_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                nz_ready = 1'b1;
                if (bus.nz_valid_i) begin
                    val_d   = bus.nz_val_i;
                    col_d   = bus.nz_col_i;
                    last_d  = bus.nz_last_i;
                    state_d = FETCH;
                end
            end
            FETCH: begin
`ifdef SPMM_SKIP_ZERO_EN
                if (val_q == '0) begin
                    state_d = last_q ? EMIT : IDLE;
                end else begin
                    b_req   = 1'b1;
                    state_d = WAIT;
                end
`else
                b_req   = 1'b1;
                state_d = WAIT;
`endif
            end
            WAIT: begin
                if (bus.b_rvalid_i) begin
                    brow_d  = bus.b_rdata_i;
                    state_d = MAC;
                end
            end
            MAC: begin
                for (int l = 0; l < LANES; l++) begin
                    acc_d[l*DATA_W +: DATA_W] = acc_q[l*DATA_W +: DATA_W] + prod[l*DATA_W +: DATA_W];
                end
                nnz_cnt_d = nnz_cnt_q + 1'b1;
                state_d   = last_q ? EMIT : IDLE;
            end
            EMIT: begin
                c_valid = 1'b1;
                if (bus.c_ready_i) begin
                    acc_d     = '0;
                    row_cnt_d = row_cnt_q + 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is held, not just after the reset edge.
    assign bus.nz_ready_o = nz_ready & rst_ni;
    assign bus.b_req_o    = b_req & rst_ni;
    assign bus.b_addr_o   = rst_ni ? col_q : '0;
    assign bus.c_valid_o  = c_valid & rst_ni;
    assign bus.busy_o     = rst_ni && (state_q != IDLE);
    assign bus.c_row_o    = acc_q;
    assign bus.row_cnt_o  = row_cnt_q;
    assign bus.nnz_cnt_o  = nnz_cnt_q;

endmodule

// File: tb/tb_spmm_row_scheduler.sv
// Directed and randomized bench for spmm_row_scheduler against a lane-arithmetic row model.
module tb_spmm_row_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [127:0] bmem [256];
    bit   [31:0]  exp_acc [4];
    bit   [15:0]  exp_rows;
    bit   [15:0]  exp_nnz;

    spmm_row_scheduler_if bus_if ();

    spmm_row_scheduler dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] acc_row();
        logic [127:0] r;
        for (int l = 0; l < 4; l++) r[l*32 +: 32] = exp_acc[l];
        return r;
    endfunction

    task automatic model_clear();
        for (int l = 0; l < 4; l++) exp_acc[l] = 32'd0;
    endtask

    // Present one nonzero, serve its B read after lat cycles, and check per-phase behaviour.
    task automatic do_nz(input logic [31:0] v, input logic [7:0] c, input bit last,
                         input int lat, input bit junk);
        bit skip;
        int n;
`ifdef SPMM_SKIP_ZERO_EN
        skip = (v == 32'd0);
`else
        skip = 1'b0;
`endif
        bus_if.nz_valid_i = 1'b1;
        bus_if.nz_val_i   = v;
        bus_if.nz_col_i   = c;
        bus_if.nz_last_i  = last;
        n = 0;
        while (bus_if.nz_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 128'(n < 50), 128'd1);
        @(negedge clk);
        bus_if.nz_valid_i = 1'b0;
        bus_if.nz_val_i   = $urandom();
        bus_if.nz_col_i   = 8'($urandom());
        chk("fetch_ready", bus_if.nz_ready_o, 1'b0);
        chk("fetch_req", bus_if.b_req_o, !skip);
        if (!skip) chk("fetch_addr", bus_if.b_addr_o, c);
        if (junk) begin
            bus_if.b_rvalid_i = 1'b1;
            bus_if.b_rdata_i  = {4{$urandom()}};
        end
        @(negedge clk);
        bus_if.b_rvalid_i = 1'b0;
        if (!skip) begin
            for (int i = 1; i <= lat; i++) begin
                bus_if.b_rvalid_i = (i == lat);
                bus_if.b_rdata_i  = (i == lat) ? bmem[c] : {4{$urandom()}};
                chk("wait_req", bus_if.b_req_o, 1'b0);
                chk("wait_ready", bus_if.nz_ready_o, 1'b0);
                @(negedge clk);
            end
            bus_if.b_rvalid_i = 1'b0;
            chk("mac_ready", bus_if.nz_ready_o, 1'b0);
            chk("mac_req", bus_if.b_req_o, 1'b0);
            for (int l = 0; l < 4; l++) exp_acc[l] = exp_acc[l] + v * bmem[c][l*32 +: 32];
            exp_nnz++;
            @(negedge clk);
        end
        chk("acc_row", bus_if.c_row_o, acc_row());
        chk("nnz_cnt", bus_if.nnz_cnt_o, exp_nnz);
        if (last) chk("emit_valid", bus_if.c_valid_o, 1'b1);
        else      chk("idle_ready", bus_if.nz_ready_o, 1'b1);
    endtask

    // Expect EMIT, hold backpressure for hold cycles with upstream pushing, then accept.
    task automatic finish_row(input int hold);
        logic [127:0] row;
        row = acc_row();
        chk("emit_valid0", bus_if.c_valid_o, 1'b1);
        chk("emit_row", bus_if.c_row_o, row);
        if (hold > 0) begin
            bus_if.nz_valid_i = 1'b1;
            bus_if.nz_val_i   = $urandom();
            bus_if.nz_col_i   = 8'($urandom());
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", bus_if.c_valid_o, 1'b1);
            chk("hold_row", bus_if.c_row_o, row);
            chk("hold_ready", bus_if.nz_ready_o, 1'b0);
        end
        bus_if.c_ready_i = 1'b1;
        @(negedge clk);
        bus_if.c_ready_i  = 1'b0;
        bus_if.nz_valid_i = 1'b0;
        exp_rows++;
        model_clear();
        chk("post_valid", bus_if.c_valid_o, 1'b0);
        chk("post_busy", bus_if.busy_o, 1'b0);
        chk("post_acc", bus_if.c_row_o, 128'd0);
        chk("row_cnt", bus_if.row_cnt_o, exp_rows);
        chk("nnz_cnt_row", bus_if.nnz_cnt_o, exp_nnz);
    endtask

    initial begin
        int nnz;
        logic [31:0] v;
        bus_if.nz_valid_i = 1'b0;
        bus_if.nz_val_i   = '0;
        bus_if.nz_col_i   = '0;
        bus_if.nz_last_i  = 1'b0;
        bus_if.b_rvalid_i = 1'b0;
        bus_if.b_rdata_i  = '0;
        bus_if.c_ready_i  = 1'b0;
        for (int i = 0; i < 256; i++) bmem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        bmem[3] = {32'd4, 32'd3, 32'd2, 32'd1};
        bmem[5] = {32'd40, 32'd30, 32'd20, 32'd10};
        bmem[9] = {4{32'd2}};
        model_clear();
        exp_rows = 0;
        exp_nnz  = 0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", bus_if.nz_ready_o, 1'b0);
        chk("rst_req", bus_if.b_req_o, 1'b0);
        chk("rst_addr", bus_if.b_addr_o, 8'd0);
        chk("rst_valid", bus_if.c_valid_o, 1'b0);
        chk("rst_busy", bus_if.busy_o, 1'b0);
        chk("rst_row", bus_if.c_row_o, 128'd0);
        chk("rst_rows", bus_if.row_cnt_o, 16'd0);
        chk("rst_nnz", bus_if.nnz_cnt_o, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready0", bus_if.nz_ready_o, 1'b1);

        // Known-answer row, latencies 1 and 5
        do_nz(32'd2, 8'd3, 1'b0, 1, 1'b0);
        do_nz(32'd3, 8'd5, 1'b1, 5, 1'b0);
        chk("kat_row", bus_if.c_row_o, {32'd128, 32'd96, 32'd64, 32'd32});
        finish_row(0);
        chk("kat_rows", bus_if.row_cnt_o, 16'd1);
        chk("kat_nnz", bus_if.nnz_cnt_o, 16'd2);

        // Same row with swapped latencies plus spurious rvalid during FETCH, 10-cycle backpressure
        do_nz(32'd2, 8'd3, 1'b0, 5, 1'b1);
        do_nz(32'd3, 8'd5, 1'b1, 1, 1'b1);
        chk("kat_row2", bus_if.c_row_o, {32'd128, 32'd96, 32'd64, 32'd32});
        finish_row(10);

        // Fresh row after backpressure starts from zero
        do_nz(32'd1, 8'd3, 1'b1, 2, 1'b0);
        chk("fresh_row", bus_if.c_row_o, {32'd4, 32'd3, 32'd2, 32'd1});
        finish_row(0);

        // Truncating products and sums
        do_nz(32'hFFFF_FFFF, 8'd9, 1'b0, 2, 1'b0);
        chk("ovf1", bus_if.c_row_o, {4{32'hFFFF_FFFE}});
        do_nz(32'hFFFF_FFFF, 8'd9, 1'b1, 3, 1'b0);
        chk("ovf2", bus_if.c_row_o, {4{32'hFFFF_FFFC}});
        finish_row(0);

        // Reset during WAIT of the second nonzero
        do_nz(32'd5, 8'd11, 1'b0, 2, 1'b0);
        bus_if.nz_valid_i = 1'b1;
        bus_if.nz_val_i   = 32'd7;
        bus_if.nz_col_i   = 8'd12;
        bus_if.nz_last_i  = 1'b1;
        @(negedge clk);
        bus_if.nz_valid_i = 1'b0;
        chk("abort_fetch", bus_if.b_req_o, 1'b1);
        @(negedge clk);
        chk("abort_wait_busy", bus_if.busy_o, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ready", bus_if.nz_ready_o, 1'b0);
        chk("abort_req", bus_if.b_req_o, 1'b0);
        chk("abort_addr", bus_if.b_addr_o, 8'd0);
        chk("abort_valid", bus_if.c_valid_o, 1'b0);
        chk("abort_busy", bus_if.busy_o, 1'b0);
        chk("abort_row", bus_if.c_row_o, 128'd0);
        chk("abort_rows", bus_if.row_cnt_o, 16'd0);
        chk("abort_nnz", bus_if.nnz_cnt_o, 16'd0);
        rst_n = 1'b1;
        model_clear();
        exp_rows = 0;
        exp_nnz  = 0;
        @(negedge clk);
        chk("abort_idle", bus_if.nz_ready_o, 1'b1);
        do_nz(32'd3, 8'd5, 1'b1, 1, 1'b0);
        chk("abort_fresh", bus_if.c_row_o, {32'd120, 32'd90, 32'd60, 32'd30});
        finish_row(0);

        // Zero-valued single nonzero forms an empty row
        do_nz(32'd0, 8'd7, 1'b1, 2, 1'b0);
        chk("zero_row", bus_if.c_row_o, 128'd0);
        finish_row(0);

        // Randomized rows
        for (int r = 0; r < 20; r++) begin
            nnz = $urandom_range(1, 4);
            for (int k = 0; k < nnz; k++) begin
                v = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom();
                do_nz(v, 8'($urandom()), (k == nnz - 1), $urandom_range(1, 5),
                      1'($urandom_range(0, 1)));
            end
            finish_row($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
